// File: rtl/imem_boot_loader.sv
// Purpose : assembles a length-prefixed, checksummed byte stream into 32-bit words,
//           writes them to RAM from address 0 and releases the core after verification.
// Latency : mem_we is high one cycle after the 4th byte of a word. core_reset falls one cycle after the last checksum byte.
// Backpr. : rx_ready is low only in DONE. ERROR keeps draining bytes so the host never stalls.
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   rx_data/rx_valid/rx_ready   byte stream in (valid/ready handshake)
//   start                       one-cycle pulse, re-arms from DONE or ERROR
//   mem_we/mem_addr/mem_wdata   RAM word write port
//   core_reset                  processor reset, low only after a verified load
//   busy/done/error             loader status
module imem_boot_loader #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t      state, state_nxt;
    logic [15:0] len_q;
    logic [1:0]  byte_idx;
    logic [16:0] word_cnt;      // one bit wider than a 16-bit length so L == 65535 still terminates
    logic [23:0] asm_q;         // last three bytes received; the 4th completes the word
    logic [31:0] sum_q;

    logic        acc;
    logic [31:0] word_next;
    logic [16:0] len_full;
    logic [16:0] cnt_next;
    logic        rearm;

    assign acc       = rx_valid && rx_ready;
    assign word_next = {rx_data, asm_q};          // little-endian: first byte ends up in [7:0]
    assign len_full  = {1'b0, rx_data, len_q[7:0]};
    assign cnt_next  = word_cnt + 17'd1;
    assign rearm     = start && (state == S_DONE || state == S_ERROR);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LEN_LO;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_LEN_LO: if (acc) state_nxt = S_LEN_HI;
            S_LEN_HI: begin
                if (acc) begin
                    if (len_full == 17'd0)
                        state_nxt = S_CSUM;
                    else if (len_full > DEPTH_L)
                        state_nxt = S_ERROR;
                    else
                        state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (acc && byte_idx == 2'd3 && cnt_next == {1'b0, len_q})
                    state_nxt = S_CSUM;
            end
            S_CSUM: begin
                if (acc && byte_idx == 2'd3)
                    state_nxt = (word_next == sum_q) ? S_DONE : S_ERROR;
            end
            S_DONE:  if (start) state_nxt = S_LEN_LO;
            S_ERROR: if (start) state_nxt = S_LEN_LO;
            default: state_nxt = S_LEN_LO;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        rx_ready   = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        core_reset = 1'b1;
        case (state)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: busy = 1'b1;
            S_DONE: begin
                rx_ready   = 1'b0;
                done       = 1'b1;
                core_reset = 1'b0;
            end
            S_ERROR: error = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Datapath: length capture, word assembly, RAM write and running checksum
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q     <= '0;
            byte_idx  <= '0;
            word_cnt  <= '0;
            asm_q     <= '0;
            sum_q     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (rearm) begin
                len_q    <= '0;
                byte_idx <= '0;
                word_cnt <= '0;
                asm_q    <= '0;
                sum_q    <= '0;
            end else if (acc) begin
                case (state)
                    S_LEN_LO: len_q[7:0]  <= rx_data;
                    S_LEN_HI: len_q[15:8] <= rx_data;
                    S_DATA: begin
                        asm_q    <= word_next[31:8];
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= word_cnt[ADDR_W-1:0];
                            mem_wdata <= word_next;
                            sum_q     <= sum_q + word_next;
                            word_cnt  <= cnt_next;
                        end
                    end
                    S_CSUM: begin
                        asm_q    <= word_next[31:8];
                        byte_idx <= byte_idx + 2'd1;
                    end
                    default: ;  // bytes in ERROR are drained and dropped
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        start;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        error;

    imem_boot_loader #(.DEPTH(1024), .ADDR_W(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .start      (start),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_hs  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           n;        // bytes in stream
        logic [127:0] s;        // stream, first byte most significant, right-aligned
        int           gap;      // max random idle cycles before each byte
        int           nw;       // expected RAM writes
        logic [31:0]  w0;
        logic [31:0]  w1;
        int           term;     // byte index after which DONE/ERROR is reached
        logic         exp_done;
        logic         exp_err;
    } vec_t;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t  exp_q[$];
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every mem_we pulse must match the oldest expected write, including its cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected mem_we: addr %h data %h", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_data", mem_wdata, e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (rx_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        last_hs = cyc;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake timeout: byte %h rx_ready stuck at %b", b, rx_ready);
        end
    endtask

    task automatic push_wr(input int addr, input logic [31:0] data);
        wr_t e;
        e.addr = 10'(addr);
        e.data = data;
        e.cyc  = last_hs;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("rearm_busy", 32'(busy), 1);
        chk("rearm_error", 32'(error), 0);
        chk("rearm_done", 32'(done), 0);
        chk("rearm_core_reset", 32'(core_reset), 1);
        chk("rearm_rx_ready", 32'(rx_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            logic [7:0] b;
            int g;
            b = v.s[8*(v.n-1-i) +: 8];
            g = (v.gap > 0) ? int'($urandom_range(v.gap, 0)) : 0;
            send_byte(b, g);
            if (v.nw > 0 && i == 5) push_wr(0, v.w0);
            if (v.nw > 1 && i == 9) push_wr(1, v.w1);
            if (i == v.term) begin
                @(negedge clk);
                chk("term_done", 32'(done), 32'(v.exp_done));
                chk("term_error", 32'(error), 32'(v.exp_err));
                chk("term_core_reset", 32'(core_reset), 32'(!v.exp_done));
            end
        end
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("end_done", 32'(done), 32'(v.exp_done));
        chk("end_error", 32'(error), 32'(v.exp_err));
        chk("end_busy", 32'(busy), 0);
        chk("end_rx_ready", 32'(rx_ready), 32'(!v.exp_done));
        chk("end_pending_writes", exp_q.size(), 0);
        if (v.nw > 0) chk("end_mem_addr_held", 32'(mem_addr), 32'(v.nw - 1));
        @(posedge clk);
        #1;
        pulse_start();
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        start    = 1'b0;

        // Case 1: good two-word program, continuous valid
        vecs[0] = '{n: 14, s: 128'h0200_13000000_93001000_A6001000, gap: 0, nw: 2,
                    w0: 32'h00000013, w1: 32'h00100093, term: 13, exp_done: 1'b1, exp_err: 1'b0};
        // Same program with random idle gaps
        vecs[1] = vecs[0];
        vecs[1].gap = 5;
        // Bad checksum plus two trailing bytes that must still be drained
        vecs[2] = '{n: 16, s: 128'h0200_13000000_93001000_A7001000_AA55, gap: 0, nw: 2,
                    w0: 32'h00000013, w1: 32'h00100093, term: 13, exp_done: 1'b0, exp_err: 1'b1};
        // Empty program: zero length, zero checksum
        vecs[3] = '{n: 6, s: 128'h0000_00000000, gap: 0, nw: 0,
                    w0: 32'h0, w1: 32'h0, term: 5, exp_done: 1'b1, exp_err: 1'b0};
        // L = 1025 > DEPTH: error right after the length, following bytes discarded
        vecs[4] = '{n: 4, s: 128'h0104_FFEE, gap: 0, nw: 0,
                    w0: 32'h0, w1: 32'h0, term: 1, exp_done: 1'b0, exp_err: 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_ready", 32'(rx_ready), 1);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_core_reset", 32'(core_reset), 1);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int k = 0; k < 5; k++) run_vec(vecs[k]);

        // Reset after 6 bytes of case 1 (word 0 already written), then resend the whole stream
        begin
            logic [47:0] part;
            part = 48'h0200_13000000;
            for (int i = 0; i < 6; i++) send_byte(part[8*(5-i) +: 8], 0);
            push_wr(0, 32'h00000013);
            rx_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            @(negedge clk);
            chk("midrst_busy", 32'(busy), 1);
            chk("midrst_rx_ready", 32'(rx_ready), 1);
            chk("midrst_mem_addr", 32'(mem_addr), 0);
            chk("midrst_done", 32'(done), 0);
            @(posedge clk);
            #1;
            run_vec(vecs[0]);
        end

        // L == DEPTH fills the RAM exactly
        begin
            logic [31:0] sum;
            logic [31:0] w;
            sum = 32'h0;
            send_byte(8'h00, 0);
            send_byte(8'h04, 0);
            for (int k = 0; k < 1024; k++) begin
                w = 32'(k) * 32'h01010003 + 32'h5;
                sum = sum + w;
                for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], 0);
                push_wr(k, w);
            end
            for (int j = 0; j < 4; j++) send_byte(sum[8*j +: 8], 0);
            rx_valid = 1'b0;
            @(negedge clk);
            chk("full_done", 32'(done), 1);
            chk("full_core_reset", 32'(core_reset), 0);
            chk("full_last_addr", 32'(mem_addr), 1023);
            chk("full_pending_writes", exp_q.size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder for the multicycle core's unified instruction/data RAM.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes the words sequentially into RAM from word address 0, verifies a trailing 32-bit additive checksum, then releases the core from reset.
- Sits between the host serial receiver and the RAM write port; the core is held in reset until the load completes.

Parameters:
- DEPTH, 1024, RAM depth in words; maximum accepted program length.
- ADDR_W, 10, word-address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte; transfer occurs when rx_valid && rx_ready on a rising clk edge
- start  in  1  one-cycle pulse; re-arms the loader from DONE or ERROR
- mem_we  out  1  RAM write enable, one-cycle pulse per word
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  32  RAM write data
- core_reset  out  1  reset to the processor; high until a verified load completes
- busy  out  1  high in LEN_LO, LEN_HI, DATA, CSUM
- done  out  1  high in DONE
- error  out  1  high in ERROR

Behaviour:
- One clock domain. Reset is synchronous and active-high: clk, reset.
- Reset values:
  - State = LEN_LO.
  - rx_ready = 1, busy = 1, core_reset = 1.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0, done = 0, error = 0.
  - Byte index, word counter, length and checksum accumulators cleared.
- Reset asserted mid-load aborts the load and restarts at LEN_LO. Words already written stay in RAM.
- Stream format:
  - Length L in words: 16 bits, low byte first.
  - L data words, 4 bytes each, LSB first.
  - 4-byte checksum, LSB first.
- States:
  - LEN_LO: accept byte into L[7:0], then go to LEN_HI.
  - LEN_HI: accept byte into L[15:8].
    - If L == 0, go to CSUM.
    - If L > DEPTH, go to ERROR.
    - Otherwise go to DATA.
  - DATA: shift bytes into the word assembly register.
    - On the 4th accepted byte, the next cycle must show mem_we = 1, mem_addr = word counter, and mem_wdata = the assembled word.
    - In that same cycle, sum += word (mod 2^32) and the word counter increments.
    - After word L-1 is accepted, go to CSUM.
    - rx_ready stays 1 during the write pulse, so back-to-back bytes are never stalled.
  - CSUM: assemble 4 bytes.
    - On the 4th byte: if it equals sum, go to DONE; otherwise go to ERROR.
  - DONE: rx_ready = 0, done = 1.
    - core_reset falls in the first cycle of DONE, one cycle after the final checksum byte handshake.
  - ERROR: error = 1, core_reset = 1.
    - rx_ready = 1; incoming bytes are consumed and discarded so the host never hangs.
- start:
  - In DONE or ERROR: return to LEN_LO, clear counters and sum, set core_reset = 1, clear done and error.
  - Ignored in all other states.
- Each mem_we pulse is exactly one cycle; there is never more than one pulse per 4 accepted data bytes.
- mem_addr holds its last value between pulses.
- No bytes are accepted while rx_valid = 0. Gaps of any length between bytes are legal, with no timeout.
- The length check uses L > DEPTH strictly: L == DEPTH is legal and fills the RAM exactly, with no address wrap.

Test Plan:
1. Reset, then stream 02 00 | 13 00 00 00 | 93 00 10 00 | A6 00 10 00. Required:
   - mem_we pulses at addr 0 with data 0x00000013, then at addr 1 with data 0x00100093.
   - done = 1.
   - core_reset falls one cycle after the last handshake.
2. Same stream with checksum A7 00 10 00. Required:
   - Both words are still written.
   - error = 1, core_reset stays 1, trailing bytes are consumed.
   - A start pulse then returns to busy = 1 with error = 0.
3. Stream 00 00 | 00 00 00 00. Required: no mem_we pulses, done = 1, core_reset = 0.
4. Length 01 04 (L = 1025) with DEPTH = 1024. Required: error = 1 immediately after the second byte, and mem_we is never asserted.
5. Case 1 with rx_valid held high continuously, then repeated with random 0-5 cycle gaps. Required: identical memory writes and timing relative to handshakes; no lost or duplicated bytes.
6. Assert reset after the 6th byte of case 1, then resend the full case-1 stream. Required: state restarts at LEN_LO, and the writes and completion match case 1 exactly.
